// File: rtl/cpuclk_meter.sv
// rtl/cpuclk_meter.sv - CPUCLK period/high-time meter; optional stall watchdog under CPUCLK_METER_STALL_EN
module cpuclk_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CPUCLK,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             ovf,
  output logic             stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic               rise;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic               ovfi_q, ovfi_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               ovf_q, ovf_d;
  logic               stall_q, stall_d;

  // CPUCLK is asynchronous data: two flops to settle, third for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= CPUCLK;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

`ifdef CPUCLK_METER_STALL_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expire;

  // Watchdog counts clk cycles since entering ARM or since the last rise
  always_comb begin
    wd_d = '0;
    if (state_q != IDLE && !rise) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  assign wd_expire = (state_q != IDLE) && !rise && (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign stall = stall_q;
`else
  logic unused_timeout;

  assign unused_timeout = TIMEOUT[0];
  assign stall          = 1'b0;
`endif

  // Next-state and measurement datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    ovfi_d   = ovfi_q;
    done_d   = 1'b0;
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    stall_d  = stall_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
          ovfi_d  = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          // The terminating rise also opens the next measurement in continuous mode
          period_d = cnt_q;
          high_d   = hcnt_q;
          ovf_d    = ovfi_q;
          stall_d  = 1'b0;
          done_d   = 1'b1;
          cnt_d    = CNT_W'(1);
          hcnt_d   = CNT_W'(1);
          ovfi_d   = 1'b0;
          if (!cont) begin
            state_d = IDLE;
          end
        end else begin
          if (cnt_q == '1) begin
            ovfi_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (s2_q) begin
            if (hcnt_q == '1) begin
              ovfi_d = 1'b1;
            end else begin
              hcnt_d = hcnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CPUCLK_METER_STALL_EN
    // A stalled CPU clock ends the measurement whatever the mode
    if (wd_expire) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
      ovf_d    = 1'b0;
      stall_d  = 1'b1;
      done_d   = 1'b1;
    end
`endif
  end

  // State, counters and published results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      ovfi_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      ovfi_q   <= ovfi_d;
      done_q   <= done_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      stall_q  <= stall_d;
    end
  end

`ifndef CPUCLK_METER_STALL_EN
  logic unused_stall;

  assign unused_stall = stall_q;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign period   = period_q;
  assign high_cnt = high_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_cpuclk_meter.sv
// tb/tb_cpuclk_meter.sv - directed self-checking bench for cpuclk_meter
module tb_cpuclk_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPUCLK = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;

  logic        busy, done, ovf, stall;
  logic [15:0] period, high_cnt;
  logic        busy4, done4, ovf4, stall4;
  logic [3:0]  period4, high4;

  int n_checks = 0;
  int n_fail   = 0;

  int hi_len = 2;
  int lo_len = 2;
  bit run    = 1'b1;

  cpuclk_meter #(.CNT_W(16), .TIMEOUT(40)) u16 (
    .clk(clk), .rst(rst), .CPUCLK(CPUCLK), .start(start), .cont(cont),
    .busy(busy), .done(done), .period(period), .high_cnt(high_cnt),
    .ovf(ovf), .stall(stall)
  );

  cpuclk_meter #(.CNT_W(4), .TIMEOUT(40)) u4 (
    .clk(clk), .rst(rst), .CPUCLK(CPUCLK), .start(start), .cont(cont),
    .busy(busy4), .done(done4), .period(period4), .high_cnt(high4),
    .ovf(ovf4), .stall(stall4)
  );

  always #5 clk = ~clk;

  // CPUCLK source, changes only on falling clk edges
  initial begin
    forever begin
      if (run) begin
        CPUCLK = 1'b1;
        repeat (hi_len) @(negedge clk);
        CPUCLK = 1'b0;
        repeat (lo_len) @(negedge clk);
      end else begin
        CPUCLK = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns number of falling edges until done is seen; flags a timeout as a failure
  task automatic wait_done(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= max_cyc) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'(max_cyc + 1));
        break;
      end
    end
  endtask

  task automatic count_dones(input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) k++;
    end
  endtask

  initial begin
    int c;
    int k;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_stall", 32'(stall), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // clk/4 single shot
    pulse_start();
    chk("ss_busy", 32'(busy), 1);
    wait_done("ss", 20, c);
    chk("ss_latency_le11", 32'(c <= 10), 1);
    chk("ss_period", 32'(period), 4);
    chk("ss_high", 32'(high_cnt), 2);
    chk("ss_ovf", 32'(ovf), 0);
    chk("ss_busy_at_done", 32'(busy), 0);
    @(negedge clk);
    chk("ss_done_one_cycle", 32'(done), 0);

    // 3 high / 5 low continuous
    hi_len = 3;
    lo_len = 5;
    repeat (20) @(negedge clk);
    cont = 1'b1;
    pulse_start();
    wait_done("ct1", 40, c);
    chk("ct1_period", 32'(period), 8);
    chk("ct1_high", 32'(high_cnt), 3);
    chk("ct1_busy", 32'(busy), 1);
    wait_done("ct2", 40, c);
    chk("ct2_spacing", 32'(c), 8);
    chk("ct2_period", 32'(period), 8);
    chk("ct2_high", 32'(high_cnt), 3);
    cont = 1'b0;
    wait_done("ct3", 40, c);
    chk("ct3_spacing", 32'(c), 8);
    chk("ct3_period", 32'(period), 8);
    chk("ct3_busy_low", 32'(busy), 0);
    count_dones(30, k);
    chk("ct_no_more_done", 32'(k), 0);

    // clk/32: saturates the 4-bit instance only
    hi_len = 16;
    lo_len = 16;
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done("sat", 120, c);
    chk("sat16_period", 32'(period), 32);
    chk("sat16_high", 32'(high_cnt), 16);
    chk("sat16_ovf", 32'(ovf), 0);
    chk("sat4_done", 32'(done4), 1);
    chk("sat4_period", 32'(period4), 15);
    chk("sat4_high", 32'(high4), 15);
    chk("sat4_ovf", 32'(ovf4), 1);

    hi_len = 2;
    lo_len = 2;
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done("ovfclr", 20, c);
    chk("ovfclr4_period", 32'(period4), 4);
    chk("ovfclr4_high", 32'(high4), 2);
    chk("ovfclr4_ovf", 32'(ovf4), 0);

    // Reset mid-measurement
    hi_len = 16;
    lo_len = 16;
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_period", 32'(period), 0);
    chk("mid_high", 32'(high_cnt), 0);
    chk("mid_ovf4", 32'(ovf4), 0);
    chk("mid_period4", 32'(period4), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_dones(60, k);
    chk("mid_no_done", 32'(k), 0);
    chk("mid_idle", 32'(busy), 0);
    hi_len = 2;
    lo_len = 2;
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done("mid_after", 20, c);
    chk("mid_after_period", 32'(period), 4);
    chk("mid_after_high", 32'(high_cnt), 2);

    // start while busy is ignored
    hi_len = 3;
    lo_len = 5;
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    pulse_start();
    wait_done("ign", 40, c);
    chk("ign_period", 32'(period), 8);
    chk("ign_busy", 32'(busy), 0);
    count_dones(40, k);
    chk("ign_single_done", 32'(k), 0);

    // Stuck CPUCLK
    run = 1'b0;
    repeat (10) @(negedge clk);
`ifdef CPUCLK_METER_STALL_EN
    pulse_start();
    wait_done("stall", 80, c);
    chk("stall_latency", 32'(c >= 38 && c <= 41), 1);
    chk("stall_flag", 32'(stall), 1);
    chk("stall_period", 32'(period), 0);
    chk("stall_high", 32'(high_cnt), 0);
    chk("stall_busy", 32'(busy), 0);
    run = 1'b1;
    hi_len = 2;
    lo_len = 2;
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done("unstall", 20, c);
    chk("unstall_flag", 32'(stall), 0);
    chk("unstall_period", 32'(period), 4);
`else
    pulse_start();
    count_dones(100, k);
    chk("nostall_no_done", 32'(k), 0);
    chk("nostall_busy", 32'(busy), 1);
    chk("nostall_stall", 32'(stall), 0);
    hi_len = 2;
    lo_len = 2;
    run = 1'b1;
    wait_done("resume", 20, c);
    chk("resume_period", 32'(period), 4);
    chk("resume_stall", 32'(stall), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cpuclk_meter.md
# cpuclk_meter

Measures the CPUCLK produced by the clock divider. It runs on the board clock `clk`, detects CPUCLK rising edges and reports the period and high time of one full CPUCLK cycle, counted in `clk` cycles. It can run in single-shot or continuous mode. Used by the debug/display path to confirm the divider setting chosen by `SW` and to flag a stalled CPU clock.

## Interface
- `CNT_W`, 16: width of the `period` and `high_cnt` counters.
- `TIMEOUT`, 1024: number of `clk` cycles without a CPUCLK rise before a stall is declared. Used only with `CPUCLK_METER_STALL_EN`.

Ports:
- `clk`  in  1  board clock; the only clock of the block.
- `rst`  in  1  reset; asynchronous, active-high.
- `CPUCLK`  in  1  divided clock under measurement. Sampled as data, never used as a clock.
- `start`  in  1  one-cycle request to begin a measurement. Ignored while `busy`=1.
- `cont`  in  1  continuous mode, sampled at each measurement end.
- `busy`  out  1  high in ARM or MEASURE.
- `done`  out  1  one-cycle pulse when a result is published.
- `period`  out  CNT_W  `clk` cycles between two consecutive CPUCLK rises.
- `high_cnt`  out  CNT_W  `clk` cycles CPUCLK was high within that period.
- `ovf`  out  1  a counter saturated during the published measurement.
- `stall`  out  1  sticky; the last measurement timed out. Always 0 when the macro is off.

## Operation
- **Sampling**
  - Three-flop chain: `s1`<=CPUCLK, `s2`<=`s1`, `s3`<=`s2`.
  - `rise` = `s2` & ~`s3`.
- **IDLE**
  - `start` -> ARM.
- **ARM**
  - Wait for `rise`.
  - On `rise` -> MEASURE, with `cnt`<=1 and `hcnt`<=1.
- **MEASURE**, each cycle without `rise`:
  - `cnt`<=`cnt`+1.
  - `hcnt`<=`hcnt`+`s2`.
  - Both counters saturate at all-ones; saturation sets internal `ovf_i`.
- **MEASURE**, on `rise`:
  - Publish `period`<=`cnt`, `high_cnt`<=`hcnt`, `ovf`<=`ovf_i`, `stall`<=0.
  - Pulse `done`.
  - If `cont`=1: stay in MEASURE, reload `cnt`=1 and `hcnt`=1, clear `ovf_i`. The terminating rise is the start edge of the next measurement.
  - If `cont`=0: go to IDLE.
- `start` while busy has no effect.
- `start` in the same cycle as a `cont`=0 completion is dropped; the FSM is still busy in that cycle.
- Outputs hold their last published values until the next publish.
- **Reset values**, asynchronous:
  - FSM = IDLE.
  - `s1`/`s2`/`s3` = 0.
  - `busy`=0, `done`=0, `period`=0, `high_cnt`=0, `ovf`=0, `stall`=0.
- Reset mid-measurement abandons the measurement without publishing or pulsing `done`.

## Timing
- A CPUCLK rise is first seen as `rise` 2 `clk` cycles after it is sampled into `s1`.
- `done`, `period`, `high_cnt` and `ovf` are registered. They are valid in the cycle after the terminating `rise` cycle.
- `busy` asserts the cycle after `start` and deasserts in the same cycle `done` asserts when `cont`=0.
- Worked case, CPUCLK = clk/4 (2 high, 2 low), `start` accepted:
  - First `done` comes at most 4 + 4 + 3 cycles after `start`.
  - `period`=4, `high_cnt`=2.
  - In continuous mode, `done` then repeats every 4 cycles.
- A CPUCLK high or low phase shorter than one `clk` cycle is outside the supported range and may be missed.

## Configuration
- **`CPUCLK_METER_STALL_EN` defined:** a watchdog counter runs in ARM and MEASURE and is cleared by every `rise`. When it reaches `TIMEOUT`:
  - publish `period`=0, `high_cnt`=0, `ovf`=0, `stall`=1;
  - pulse `done`;
  - go to IDLE, regardless of `cont`.
- **Not defined:** no watchdog. ARM and MEASURE wait indefinitely, `stall` is tied to 0, and `TIMEOUT` is unused.

## Test plan
- CPUCLK = clk/4 with 50% duty; pulse `start` with `cont`=0 -> one `done` pulse, `period`=4, `high_cnt`=2, `busy` then low.
- CPUCLK with 3 `clk` high and 5 `clk` low; `cont`=1 -> `done` every 8 cycles with `period`=8, `high_cnt`=3. Drop `cont` -> the next `done` is the last and `busy` falls.
- `CNT_W`=4 and CPUCLK = clk/32 -> `period`=15, `ovf`=1. A following clk/4 measurement -> `ovf`=0.
- With the macro and `TIMEOUT`=16, CPUCLK stuck at 0, `start` -> `done` 16 cycles into ARM (±1), `stall`=1, `period`=0. A later valid measurement clears `stall`.
- Assert `rst` mid-MEASURE -> all outputs 0 immediately, no `done`. After release, `start` measures normally.
- `start` pulsed while busy -> ignored, exactly one `done` produced.
